// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR-flop request arbiter: FSM states, flop command
// encodings and the gap-counter width.
package sr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    ACK,
    GAP
  } sr_state_e;

  // Bit 1 drives the flop's s input, bit 0 drives r.
  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    RESET   = 2'b01,
    SET     = 2'b10,
    INVALID = 2'b11
  } sr_cmd_e;

  localparam int GAP_W = 4;

  function automatic sr_cmd_e cmd_for(input logic dir);
    return dir ? SET : RESET;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: first asserted request at or after
// ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic                 valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int PW = $clog2(N);

  logic [PW:0]   sum_reg_free [N];
  logic [PW-1:0] slot [N];
  logic [N-1:0]  hit;

  // slot[gi] is the requester index examined at priority position gi.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      assign sum_reg_free[gi] = {1'b0, ptr} + (PW + 1)'(gi);
      assign slot[gi] = (sum_reg_free[gi] >= (PW + 1)'(N))
                      ? PW'(sum_reg_free[gi] - (PW + 1)'(N))
                      : sum_reg_free[gi][PW-1:0];
      assign hit[gi] = req[slot[gi]];
    end
  endgenerate

  always_comb begin
    valid     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    // Scan from lowest priority upward so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        valid     = 1'b1;
        grant_idx = slot[k];
      end
    end
    grant[grant_idx] = valid;
  end

endmodule

// File: rtl/sr_req_arbiter.sv
// Round-robin front end for one shared SR flop: issues single-cycle legal s/r
// pulses, verifies q, acknowledges the winner and enforces an idle gap.
module sr_req_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  output logic [N_REQ-1:0] ack,
  output logic             s_out,
  output logic             r_out,
  input  logic             q_in,
  output logic             busy,
  output logic [N_REQ-1:0] illegal_err,
  output logic             mismatch_err
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;
  localparam sr_state_e AFTER_OP = (MIN_GAP > 0) ? GAP : IDLE;

  logic [N_REQ-1:0] valid_req;
  logic [N_REQ-1:0] both_req;
  logic [N_REQ-1:0] arb_grant;
  logic [N_REQ-1:0] grant_oh;
  logic             arb_valid;
  logic [PW-1:0]    arb_idx;
  logic             win_dir;

  sr_state_e        state_reg;
  sr_cmd_e          cmd_reg;
  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    grant_reg;
  logic             dir_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [N_REQ-1:0] ack_reg;
  logic [N_REQ-1:0] illegal_reg;
  logic             mismatch_reg;

  // A requester asking for both set and clear is excluded from arbitration.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign valid_req[gi] = set_req[gi] ^ clr_req[gi];
      assign both_req[gi]  = set_req[gi] & clr_req[gi];
      assign grant_oh[gi]  = (grant_reg == PW'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .req       (valid_req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .valid     (arb_valid),
    .grant_idx (arb_idx)
  );

  assign win_dir = set_req[arb_idx];

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    return (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cmd_reg      <= HOLD;
      ptr_reg      <= '0;
      grant_reg    <= '0;
      dir_reg      <= 1'b0;
      gap_reg      <= '0;
      ack_reg      <= '0;
      illegal_reg  <= '0;
      mismatch_reg <= 1'b0;
    end else begin
      cmd_reg <= HOLD;
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          illegal_reg <= illegal_reg | both_req;
          if (arb_valid) begin
            grant_reg <= arb_idx;
            dir_reg   <= win_dir;
            if (win_dir == q_in) begin
              // Flop already holds the requested value: acknowledge without a pulse.
              state_reg <= ACK;
              ack_reg   <= arb_grant;
              ptr_reg   <= ptr_after(arb_idx);
            end else begin
              state_reg <= ISSUE;
              cmd_reg   <= cmd_for(win_dir);
            end
          end
        end
        ISSUE: state_reg <= CHECK;
        CHECK: begin
          ptr_reg <= ptr_after(grant_reg);
          if (q_in == dir_reg) begin
            state_reg <= ACK;
            ack_reg   <= grant_oh;
          end else begin
            // Request stays pending; pointer still advances so others get a turn.
            mismatch_reg <= 1'b1;
            state_reg    <= AFTER_OP;
            gap_reg      <= GAP_LOAD;
          end
        end
        ACK: begin
          state_reg <= AFTER_OP;
          gap_reg   <= GAP_LOAD;
        end
        GAP: begin
          if (gap_reg == '0) state_reg <= IDLE;
          else               gap_reg   <= gap_reg - GAP_W'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack          = ack_reg;
  assign s_out        = cmd_reg[1];
  assign r_out        = cmd_reg[0];
  assign busy         = (state_reg != IDLE);
  assign illegal_err  = illegal_reg;
  assign mismatch_err = mismatch_reg;

endmodule

// File: tb/tb_sr_req_arbiter.sv
// Randomized scoreboard bench for sr_req_arbiter (MIN_GAP=2) plus a small
// MIN_GAP=0 instance checking back-to-back command spacing.
module tb_sr_req_arbiter;

  localparam int N       = 4;
  localparam int MG      = 2;
  localparam int RUN_CYC = 3000;
  localparam int QUIET   = 2800;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic g_rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] set_req, clr_req, ack, illegal_err;
  logic         s_out, r_out, q_in, busy, mismatch_err;
  logic [N-1:0] g_set, g_clr, g_ack, g_ill;
  logic         g_s, g_r, g_busy, g_mm;

  logic q_flop = 1'b0;
  logic g_q    = 1'b0;
  logic stuck  = 1'b0;

  // Behavioural SR flops in front of which the arbiters sit.
  always @(posedge clk) begin
    if (s_out)      q_flop <= 1'b1;
    else if (r_out) q_flop <= 1'b0;
    if (g_s)        g_q <= 1'b1;
    else if (g_r)   g_q <= 1'b0;
  end
  assign q_in = stuck ? 1'b0 : q_flop;

  sr_req_arbiter #(.N_REQ(N), .MIN_GAP(MG)) u_dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .ack(ack),
    .s_out(s_out), .r_out(r_out), .q_in(q_in), .busy(busy),
    .illegal_err(illegal_err), .mismatch_err(mismatch_err)
  );

  sr_req_arbiter #(.N_REQ(N), .MIN_GAP(0)) u_gap0 (
    .clk(clk), .rst_n(g_rst_n), .set_req(g_set), .clr_req(g_clr), .ack(g_ack),
    .s_out(g_s), .r_out(g_r), .q_in(g_q), .busy(g_busy),
    .illegal_err(g_ill), .mismatch_err(g_mm)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int idx; int at;} ack_t;
  typedef struct {bit dir; int at;} pulse_t;
  ack_t   ack_q[$];
  pulse_t pulse_q[$];
  ack_t   ma;
  pulse_t mp;

  // Transaction-level reference: requester status 0 idle, 1 pending, 2 granted, 3 illegal.
  int           rs[N];
  bit           pdir[N];
  int           ack_at[N];
  int           drop_at[N];
  int           hold_until[N];
  int           ill_until[N];
  logic [N-1:0] drv_set = '0;
  logic [N-1:0] drv_clr = '0;
  int           ptr_m = 0;
  bit           q_m = 1'b0;
  int           next_dec = 2;
  logic [N-1:0] exp_ill = '0;
  int           mm_at = -1;
  int           busy_from = 0;
  int           busy_to = -1;
  int           last_dec = -100;
  bit           last_pulsed = 1'b0;
  int           g_next = 6;
  int           g_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: observes each cycle's outputs and pops the scoreboard.
  always @(posedge clk) begin
    #1;
    chk("s_and_r", 32'(s_out & r_out), 32'd0);
    if (s_out | r_out) begin
      if (pulse_q.size() == 0) chk("unexpected_pulse", {30'd0, s_out, r_out}, 32'd0);
      else begin
        mp = pulse_q.pop_front();
        $display("pulse cyc=%0d s=%0b r=%0b", cyc, s_out, r_out);
        chk("pulse_cycle", cyc, mp.at);
        chk("pulse_sr", {30'd0, s_out, r_out}, {30'd0, mp.dir, ~mp.dir});
      end
    end else if (pulse_q.size() != 0 && pulse_q[0].at < cyc) begin
      chk("missing_pulse", cyc, pulse_q[0].at);
      void'(pulse_q.pop_front());
    end
    if (ack != '0) begin
      $display("ack   cyc=%0d ack=%b", cyc, ack);
      if (ack_q.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
      else begin
        ma = ack_q.pop_front();
        chk("ack_cycle", cyc, ma.at);
        chk("ack_vector", 32'(ack), 32'(1) << ma.idx);
      end
    end else if (ack_q.size() != 0 && ack_q[0].at < cyc) begin
      chk("missing_ack", cyc, ack_q[0].at);
      void'(ack_q.pop_front());
    end
    chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
    chk("illegal_err", 32'(illegal_err), 32'(exp_ill));
    chk("mismatch_err", 32'(mismatch_err), 32'(mm_at >= 0 && cyc >= mm_at));
    chk("g_s_and_r", 32'(g_s & g_r), 32'd0);
    if (g_ack != '0) begin
      $display("g_ack cyc=%0d ack=%b", cyc, g_ack);
      chk("g_ack_vector", 32'(g_ack), 32'd1);
      chk("g_ack_cycle", cyc, g_next);
      g_next += 4;
      g_cnt++;
    end
  end

  // Driver plus reference model; inputs for cycle c are applied 2 time units after its edge.
  initial begin
    int c, w, j, r, pend;
    bit dir, qe;
    for (int i = 0; i < N; i++) begin
      rs[i] = 0; pdir[i] = 1'b0; ack_at[i] = -1; drop_at[i] = -1;
      hold_until[i] = 0; ill_until[i] = 0;
    end
    set_req = '0; clr_req = '0; g_set = '0; g_clr = '0;
    while (cyc < RUN_CYC) begin
      @(posedge clk);
      #2;
      c = cyc;
      if (c >= 2) begin rst_n = 1'b1; g_rst_n = 1'b1; end

      // MIN_GAP=0 instance: requester 0 alternates set/clear, each needs a pulse.
      if (c >= 3 && c < 27) begin
        g_set[0] = (((c - 3) / 4) % 2 == 0);
        g_clr[0] = ~g_set[0];
      end else begin
        g_set[0] = 1'b0; g_clr[0] = 1'b0;
      end

      for (int i = 0; i < N; i++) begin
        case (rs[i])
          2: begin
            if (c == ack_at[i]) begin
              drv_set[i] = 1'b0; drv_clr[i] = 1'b0; rs[i] = 0; hold_until[i] = c;
            end else if (c == drop_at[i]) begin
              drv_set[i] = 1'b0; drv_clr[i] = 1'b0;
            end
          end
          3: if (c >= ill_until[i]) begin
            drv_set[i] = 1'b0; drv_clr[i] = 1'b0; rs[i] = 0; hold_until[i] = c;
          end
          0: if (c > hold_until[i] && c < QUIET && (c >= 10 || (c == 3 && i == 0))) begin
            r = (c == 3) ? 0 : int'($urandom_range(0, 99));
            if (r < 8) begin
              rs[i] = 1;
              pdir[i] = (c == 3) ? 1'b1 : 1'($urandom_range(0, 1));
              drv_set[i] = pdir[i]; drv_clr[i] = ~pdir[i];
            end else if (r == 8) begin
              rs[i] = 3; drv_set[i] = 1'b1; drv_clr[i] = 1'b1;
              ill_until[i] = c + int'($urandom_range(2, 8));
            end
          end
          default: ;
        endcase
      end

      if (c >= next_dec) begin
        if (!stuck && c >= 20 && c < QUIET && $urandom_range(0, 99) == 0) stuck = 1'b1;
        else if (stuck && (c >= QUIET || $urandom_range(0, 14) == 0)) stuck = 1'b0;
      end

      if (c == last_dec + 2 && last_pulsed && c >= 20 && c < QUIET && $urandom_range(0, 9) == 0) begin
        // Reset while the DUT sits in CHECK: operation abandoned, requester stays pending.
        $display("reset cyc=%0d", c);
        rst_n = 1'b0;
        while (ack_q.size() != 0 && ack_q[$].at > c) void'(ack_q.pop_back());
        for (int i = 0; i < N; i++) if (rs[i] == 2) begin
          rs[i] = 1; drop_at[i] = -1; drv_set[i] = pdir[i]; drv_clr[i] = ~pdir[i];
        end
        ptr_m = 0; exp_ill = '0; mm_at = -1; busy_to = c; next_dec = c + 1;
      end else if (c >= next_dec) begin
        exp_ill |= drv_set & drv_clr;
        w = -1;
        for (int k = 0; k < N; k++) begin
          j = (ptr_m + k) % N;
          if (w < 0 && rs[j] == 1) w = j;
        end
        if (w >= 0) begin
          dir = pdir[w];
          qe = stuck ? 1'b0 : q_m;
          ptr_m = (w + 1) % N;
          last_dec = c;
          busy_from = c + 1;
          if (dir == qe) begin
            last_pulsed = 1'b0;
            rs[w] = 2; ack_at[w] = c + 1; drop_at[w] = -1;
            ack_q.push_back('{idx: w, at: c + 1});
            next_dec = c + 2 + MG;
          end else begin
            last_pulsed = 1'b1;
            pulse_q.push_back('{dir: dir, at: c + 1});
            q_m = dir;
            if (stuck) begin
              if (mm_at < 0) mm_at = c + 3;
              next_dec = c + 3 + MG;
            end else begin
              rs[w] = 2; ack_at[w] = c + 3;
              drop_at[w] = ($urandom_range(0, 3) == 0) ? c + 1 : -1;
              ack_q.push_back('{idx: w, at: c + 3});
              next_dec = c + 4 + MG;
            end
          end
          busy_to = next_dec - 1;
        end
      end
      set_req = drv_set;
      clr_req = drv_clr;
    end

    @(posedge clk);
    #3;
    pend = 0;
    for (int i = 0; i < N; i++) if (rs[i] == 1) pend++;
    chk("pending_left", pend, 0);
    chk("ack_q_empty", ack_q.size(), 0);
    chk("pulse_q_empty", pulse_q.size(), 0);
    chk("g_ack_count", g_cnt, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
